alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 117 +++++++++++
 tb/tb_alu_arbiter.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of one shared combinational ALU (round-robin on ties).
// Latency: request accepted on edge T, result registered on edge T+1, held valid until consumed.
// Backpressure: requests wait while an operation is in flight; a response holds until its owner takes it.
module alu_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH   = 6
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_req_valid_0,
  input  logic                  i_req_valid_1,
  output logic                  o_req_ready_0,
  output logic                  o_req_ready_1,
  input  logic [OP_WIDTH-1:0]   i_op_0,
  input  logic [OP_WIDTH-1:0]   i_op_1,
  input  logic [DATA_WIDTH-1:0] i_a_0,
  input  logic [DATA_WIDTH-1:0] i_b_0,
  input  logic [DATA_WIDTH-1:0] i_a_1,
  input  logic [DATA_WIDTH-1:0] i_b_1,
  output logic                  o_rsp_valid_0,
  output logic                  o_rsp_valid_1,
  input  logic                  i_rsp_ready_0,
  input  logic                  i_rsp_ready_1,
  output logic [DATA_WIDTH-1:0] o_rsp_data_0,
  output logic [DATA_WIDTH-1:0] o_rsp_data_1,
  output logic [OP_WIDTH-1:0]   o_alu_op,
  output logic [DATA_WIDTH-1:0] o_alu_a,
  output logic [DATA_WIDTH-1:0] o_alu_b,
  input  logic [DATA_WIDTH-1:0] i_alu_c,
  output logic                  o_busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic                  ptr;       // requester that wins when both are valid
  logic                  owner;     // requester whose operation is in flight
  logic                  grant_1;   // requester 1 would win arbitration this cycle
  logic                  accept;    // request handshake on this edge
  logic                  rsp_done;  // owner consumes its response on this edge
  logic [OP_WIDTH-1:0]   op_q;
  logic [DATA_WIDTH-1:0] a_q;
  logic [DATA_WIDTH-1:0] b_q;
  logic [DATA_WIDTH-1:0] res_q;

  // Arbitration, handshakes and next-state selection.
  always_comb begin
    grant_1       = i_req_valid_1 && (!i_req_valid_0 || ptr);
    o_req_ready_0 = 1'b0;
    o_req_ready_1 = 1'b0;
    accept        = 1'b0;
    rsp_done      = 1'b0;
    state_nxt     = state;
    case (state)
      IDLE: begin
        // Ready is masked while reset is held so nothing appears accepted.
        o_req_ready_0 = i_rst_n && i_req_valid_0 && !grant_1;
        o_req_ready_1 = i_rst_n && grant_1;
        if (i_req_valid_0 || i_req_valid_1) begin
          accept    = 1'b1;
          state_nxt = EXEC;
        end
      end
      EXEC: state_nxt = RESP;
      RESP: begin
        rsp_done = owner ? i_rsp_ready_1 : i_rsp_ready_0;
        if (rsp_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Operand capture on accept, result capture at end of EXEC, pointer hand-off on completion.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr   <= 1'b0;
      owner <= 1'b0;
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      res_q <= '0;
    end else begin
      if (accept) begin
        owner <= grant_1;
        op_q  <= grant_1 ? i_op_1 : i_op_0;
        a_q   <= grant_1 ? i_a_1  : i_a_0;
        b_q   <= grant_1 ? i_b_1  : i_b_0;
      end
      if (state == EXEC) res_q <= i_alu_c;
      if (rsp_done)      ptr   <= ~owner;
    end
  end

  // The ALU only ever sees registered operands; responses share the result register.
  always_comb begin
    o_alu_op      = op_q;
    o_alu_a       = a_q;
    o_alu_b       = b_q;
    o_rsp_data_0  = res_q;
    o_rsp_data_1  = res_q;
    o_rsp_valid_0 = (state == RESP) && !owner;
    o_rsp_valid_1 = (state == RESP) && owner;
    o_busy        = (state != IDLE);
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus a randomized run against a transaction model.
// The shared ALU is modelled here and fed from the DUT's operand outputs.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_alu_arbiter;

  localparam logic [5:0] OP_ADD = 6'd0;
  localparam logic [5:0] OP_SUB = 6'd1;
  localparam logic [5:0] OP_AND = 6'd2;
  localparam logic [5:0] OP_OR  = 6'd3;
  localparam logic [5:0] OP_XOR = 6'd4;
  localparam logic [5:0] OP_SLL = 6'd5;
  localparam logic [5:0] OP_SRL = 6'd6;
  localparam logic [5:0] OP_SRA = 6'd7;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid_0 = 1'b0, req_valid_1 = 1'b0;
  logic        ready_0, ready_1;
  logic [5:0]  op_0 = '0, op_1 = '0;
  logic [31:0] a_0 = '0, b_0 = '0, a_1 = '0, b_1 = '0;
  logic        rsp_valid_0, rsp_valid_1;
  logic        rsp_ready_0 = 1'b0, rsp_ready_1 = 1'b0;
  logic [31:0] rsp_data_0, rsp_data_1;
  logic [5:0]  alu_op;
  logic [31:0] alu_a, alu_b, alu_c;
  logic        busy;
  int          n_checks = 0;
  int          n_fail = 0;

  wire [4:0] flags = {ready_0, ready_1, rsp_valid_0, rsp_valid_1, busy};

  function automatic logic [31:0] alu_ref(input logic [5:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_SLL:  return a << b[4:0];
      OP_SRL:  return a >> b[4:0];
      OP_SRA:  return $signed(a) >>> b[4:0];
      default: return 32'h0;
    endcase
  endfunction

  assign alu_c = alu_ref(alu_op, alu_a, alu_b);

  always #5 clk = ~clk;

  alu_arbiter #(.DATA_WIDTH(32), .OP_WIDTH(6)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid_0(req_valid_0), .i_req_valid_1(req_valid_1),
    .o_req_ready_0(ready_0), .o_req_ready_1(ready_1),
    .i_op_0(op_0), .i_op_1(op_1),
    .i_a_0(a_0), .i_b_0(b_0), .i_a_1(a_1), .i_b_1(b_1),
    .o_rsp_valid_0(rsp_valid_0), .o_rsp_valid_1(rsp_valid_1),
    .i_rsp_ready_0(rsp_ready_0), .i_rsp_ready_1(rsp_ready_1),
    .o_rsp_data_0(rsp_data_0), .o_rsp_data_1(rsp_data_1),
    .o_alu_op(alu_op), .o_alu_a(alu_a), .o_alu_b(alu_b),
    .i_alu_c(alu_c), .o_busy(busy)
  );

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_valid_0 = 1'b0; req_valid_1 = 1'b0;
    rsp_ready_0 = 1'b0; rsp_ready_1 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    req_valid_0 = 1'b1; req_valid_1 = 1'b1; op_0 = OP_ADD; a_0 = 32'h5; b_0 = 32'h6;
    #1;
    n_checks++;
    if (flags !== 5'b00000) begin
      n_fail++; $display("FAIL reset_flags: got %b expected %b", flags, 5'b00000);
    end
    n_checks++;
    if ({alu_op, alu_a, alu_b, rsp_data_0, rsp_data_1} !== 134'h0) begin
      n_fail++; $display("FAIL reset_regs: op=%h a=%h b=%h d0=%h d1=%h expected all zero",
                         alu_op, alu_a, alu_b, rsp_data_0, rsp_data_1);
    end
    @(negedge clk);
    req_valid_0 = 1'b0; req_valid_1 = 1'b0;
    rst_n = 1'b1;
    @(negedge clk); #1;
    n_checks++;
    if (flags !== 5'b00000) begin
      n_fail++; $display("FAIL reset_release_idle: got %b expected %b", flags, 5'b00000);
    end
  endtask

  task automatic test_single();
    @(negedge clk);
    req_valid_0 = 1'b1; op_0 = OP_ADD; a_0 = 32'h1; b_0 = 32'h1; rsp_ready_0 = 1'b1;
    #1;
    n_checks++;
    if (flags !== 5'b10000) begin
      n_fail++; $display("FAIL single_ready: got %b expected %b", flags, 5'b10000);
    end
    @(negedge clk);
    req_valid_0 = 1'b0; a_0 = 32'hdead; b_0 = 32'hbeef;
    #1;
    n_checks++;
    if (flags !== 5'b00001) begin
      n_fail++; $display("FAIL single_exec: got %b expected %b", flags, 5'b00001);
    end
    n_checks++;
    if ({alu_op, alu_a, alu_b} !== {OP_ADD, 32'h1, 32'h1}) begin
      n_fail++; $display("FAIL single_alu_regs: got %h/%h/%h expected %h/1/1",
                         alu_op, alu_a, alu_b, OP_ADD);
    end
    @(negedge clk); #1;
    n_checks++;
    if (flags !== 5'b00101 || rsp_data_0 !== 32'h2) begin
      n_fail++; $display("FAIL single_rsp: flags %b data %h expected 00101 data 2", flags, rsp_data_0);
    end
    n_checks++;
    if (rsp_data_1 !== 32'h2) begin
      n_fail++; $display("FAIL single_data_shared: got %h expected 2", rsp_data_1);
    end
    @(negedge clk); #1;
    n_checks++;
    if (flags !== 5'b00000) begin
      n_fail++; $display("FAIL single_idle: got %b expected %b", flags, 5'b00000);
    end
    rsp_ready_0 = 1'b0;
  endtask

  task automatic test_priority();
    logic [4:0]  exp_f [9] = '{5'b10000, 5'b00001, 5'b00101, 5'b01000, 5'b00001,
                               5'b00011, 5'b10000, 5'b00001, 5'b00101};
    logic [31:0] exp_d [9] = '{0, 0, 32'h0, 0, 0, 32'h00010101, 0, 0, 32'h5};
    do_reset();
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (i == 0) begin
        req_valid_0 = 1'b1; op_0 = OP_SUB; a_0 = 32'h1; b_0 = 32'h1;
        req_valid_1 = 1'b1; op_1 = OP_OR; a_1 = 32'h101; b_1 = 32'h10001;
        rsp_ready_0 = 1'b1; rsp_ready_1 = 1'b1;
      end
      if (i == 1 || i == 7) req_valid_0 = 1'b0;
      if (i == 3) begin req_valid_0 = 1'b1; op_0 = OP_ADD; a_0 = 32'h2; b_0 = 32'h3; end
      if (i == 4) req_valid_1 = 1'b0;
      #1;
      n_checks++;
      if (flags !== exp_f[i]) begin
        n_fail++; $display("FAIL priority_flags[%0d]: got %b expected %b", i, flags, exp_f[i]);
      end
      if (rsp_valid_0 || rsp_valid_1) begin
        n_checks++;
        if (rsp_data_0 !== exp_d[i]) begin
          n_fail++; $display("FAIL priority_data[%0d]: got %h expected %h", i, rsp_data_0, exp_d[i]);
        end
      end
    end
    @(negedge clk); #1;
    n_checks++;
    if (flags !== 5'b00000) begin
      n_fail++; $display("FAIL priority_idle: got %b expected %b", flags, 5'b00000);
    end
    rsp_ready_0 = 1'b0; rsp_ready_1 = 1'b0;
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    req_valid_1 = 1'b1; op_1 = OP_SRA; a_1 = 32'h80000000; b_1 = 32'h1f;
    #1;
    n_checks++;
    if (flags !== 5'b01000) begin
      n_fail++; $display("FAIL bp_ready: got %b expected %b", flags, 5'b01000);
    end
    @(negedge clk);
    req_valid_1 = 1'b0; req_valid_0 = 1'b1; op_0 = OP_ADD; a_0 = 32'h7; b_0 = 32'h7;
    #1;
    n_checks++;
    if (flags !== 5'b00001) begin
      n_fail++; $display("FAIL bp_exec: got %b expected %b", flags, 5'b00001);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 3) rsp_ready_1 = 1'b1;
      #1;
      n_checks++;
      if (flags !== 5'b00011 || rsp_data_1 !== 32'hffffffff) begin
        n_fail++; $display("FAIL bp_hold[%0d]: flags %b data %h expected 00011 data ffffffff",
                           i, flags, rsp_data_1);
      end
    end
    @(negedge clk);
    req_valid_0 = 1'b0;
    #1;
    n_checks++;
    if (flags !== 5'b00000) begin
      n_fail++; $display("FAIL bp_release: got %b expected %b", flags, 5'b00000);
    end
    rsp_ready_1 = 1'b0;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    req_valid_0 = 1'b1; op_0 = OP_SLL; a_0 = 32'h1; b_0 = 32'h10; rsp_ready_0 = 1'b1;
    #1;
    n_checks++;
    if (flags !== 5'b10000) begin
      n_fail++; $display("FAIL rmid_ready: got %b expected %b", flags, 5'b10000);
    end
    @(negedge clk);
    req_valid_0 = 1'b0; rst_n = 1'b0;
    #1;
    n_checks++;
    if (flags !== 5'b00000 || {alu_op, alu_a, alu_b, rsp_data_0} !== 102'h0) begin
      n_fail++; $display("FAIL rmid_reset: flags %b op %h a %h b %h d %h expected all zero",
                         flags, alu_op, alu_a, alu_b, rsp_data_0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i != 0) @(negedge clk);
      #1;
      n_checks++;
      if (flags !== 5'b00000) begin
        n_fail++; $display("FAIL rmid_abandon[%0d]: got %b expected %b", i, flags, 5'b00000);
      end
    end
    @(negedge clk);
    req_valid_0 = 1'b1;
    @(negedge clk);
    req_valid_0 = 1'b0;
    @(negedge clk); #1;
    n_checks++;
    if (flags !== 5'b00101 || rsp_data_0 !== 32'h00010000) begin
      n_fail++; $display("FAIL rmid_reissue: flags %b data %h expected 00101 data 00010000",
                         flags, rsp_data_0);
    end
    @(negedge clk);
    rsp_ready_0 = 1'b0;
  endtask

  task automatic test_nonowner();
    @(negedge clk);
    req_valid_0 = 1'b1; op_0 = OP_XOR; a_0 = 32'hf0f0; b_0 = 32'h0ff0;
    rsp_ready_0 = 1'b0; rsp_ready_1 = 1'b1;
    @(negedge clk);
    req_valid_0 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 3) rsp_ready_0 = 1'b1;
      #1;
      n_checks++;
      if (flags !== 5'b00101 || rsp_data_0 !== 32'h0000ff00) begin
        n_fail++; $display("FAIL nonowner_hold[%0d]: flags %b data %h expected 00101 data ff00",
                           i, flags, rsp_data_0);
      end
    end
    @(negedge clk); #1;
    n_checks++;
    if (flags !== 5'b00000) begin
      n_fail++; $display("FAIL nonowner_done: got %b expected %b", flags, 5'b00000);
    end
    rsp_ready_0 = 1'b0; rsp_ready_1 = 1'b0;
  endtask

  // Transaction model: at most one operation in flight; age 1 = computing, age 2 = result offered.
  task automatic test_random();
    logic        m_pend = 1'b0, m_owner = 1'b0, m_ptr = 1'b0;
    int          m_age = 0;
    logic [5:0]  m_op = '0;
    logic [31:0] m_a = '0, m_b = '0, m_res = '0;
    logic        exp_r0, exp_r1, exp_v0, exp_v1;
    logic        acc0 = 1'b0, acc1 = 1'b0;
    do_reset();
    for (int cyc = 0; cyc < 700; cyc++) begin
      @(negedge clk);
      if (acc0) req_valid_0 = 1'b0;
      if (acc1) req_valid_1 = 1'b0;
      acc0 = 1'b0; acc1 = 1'b0;
      if (!req_valid_0 && cyc < 640 && $urandom_range(1, 0) == 1) begin
        req_valid_0 = 1'b1; op_0 = 6'($urandom_range(9, 0)); a_0 = $urandom(); b_0 = $urandom();
      end
      if (!req_valid_1 && cyc < 640 && $urandom_range(1, 0) == 1) begin
        req_valid_1 = 1'b1; op_1 = 6'($urandom_range(9, 0)); a_1 = $urandom(); b_1 = $urandom();
      end
      rsp_ready_0 = (cyc >= 640) || ($urandom_range(1, 0) == 1);
      rsp_ready_1 = (cyc >= 640) || ($urandom_range(1, 0) == 1);
      #1;
      exp_r0 = 1'b0; exp_r1 = 1'b0;
      if (!m_pend) begin
        if (req_valid_0 && req_valid_1) begin
          exp_r0 = !m_ptr; exp_r1 = m_ptr;
        end else begin
          exp_r0 = req_valid_0; exp_r1 = req_valid_1;
        end
      end
      exp_v0 = m_pend && m_age == 2 && !m_owner;
      exp_v1 = m_pend && m_age == 2 && m_owner;
      n_checks++;
      if (flags !== {exp_r0, exp_r1, exp_v0, exp_v1, m_pend}) begin
        n_fail++; $display("FAIL rand_flags cyc %0d: got %b expected %b", cyc, flags,
                           {exp_r0, exp_r1, exp_v0, exp_v1, m_pend});
      end
      if (m_pend && m_age == 1) begin
        n_checks++;
        if ({alu_op, alu_a, alu_b} !== {m_op, m_a, m_b}) begin
          n_fail++; $display("FAIL rand_alu_in cyc %0d: got %h/%h/%h expected %h/%h/%h",
                             cyc, alu_op, alu_a, alu_b, m_op, m_a, m_b);
        end
      end
      if (m_pend && m_age == 2) begin
        n_checks++;
        if ((m_owner ? rsp_data_1 : rsp_data_0) !== m_res) begin
          n_fail++; $display("FAIL rand_data cyc %0d owner %0d: got %h expected %h", cyc, m_owner,
                             m_owner ? rsp_data_1 : rsp_data_0, m_res);
        end
      end
      // Advance the model across the coming rising edge.
      if (m_pend) begin
        if (m_age == 2 && (m_owner ? rsp_ready_1 : rsp_ready_0)) begin
          m_pend = 1'b0; m_ptr = !m_owner;
        end else begin
          m_age = 2;
        end
      end else if (exp_r0 || exp_r1) begin
        m_pend = 1'b1; m_age = 1; m_owner = exp_r1;
        m_op = exp_r1 ? op_1 : op_0;
        m_a  = exp_r1 ? a_1 : a_0;
        m_b  = exp_r1 ? b_1 : b_0;
        m_res = alu_ref(m_op, m_a, m_b);
        acc0 = exp_r0; acc1 = exp_r1;
      end
    end
    n_checks++;
    if (m_pend || busy) begin
      n_fail++; $display("FAIL rand_drain: model pending %b busy %b expected 0/0", m_pend, busy);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_backpressure();
    test_reset_mid();
    test_nonowner();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
